instr_buffer_nway: RTL
======================

Name: instr_buffer_nway

Overview:
Parametrised circular instruction buffer between fetch and dispatch.
- Accepts up to FETCH_W decoded instructions per cycle from IF/BP.
- Presents up to DISP_W in-order entries to dispatch, capped by branch-stack and store-queue capacity.
- Flushes on branch mispredict.
- Generalises the 2-wide/8-deep buffer to arbitrary width and depth, with a per-cycle branch-count budget.

Parameters:
DEPTH, 8, entry count; power of 2, at least 2*max(FETCH_W,DISP_W)
FETCH_W, 2, max instructions enqueued per cycle
DISP_W, 2, max instructions offered to dispatch per cycle
MAX_BR_PER_GRP, 1, max branches allowed in one dispatch group; a branch always terminates its group

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
br_pred_wrong  in  1  mispredict flush
if_valid_in  in  FETCH_W  enqueue valids; contiguous from bit 0 (thermometer)
if_entry_in  in  FETCH_W x IBEntry_t  instruction, fd_control, pred_NPC, not_taken_NPC, bp_pred_taken
haz_nDispatched  in  $clog2(DISP_W+1)  entries consumed this cycle; never exceeds ib_nIsnBuffer
bs_nFree  in  $clog2(BS_DEPTH+1)  free branch-stack entries
sq_nAvailable  in  $clog2(DISP_W+1)  free store-queue slots, saturated at DISP_W
ib_data  out  DISP_W x IBEntry_t  offered entries; slot i = buffer[head+i]
ib_valid  out  DISP_W  thermometer, ones(ib_nIsnBuffer)
ib_nIsnBuffer  out  $clog2(DISP_W+1)  dispatchable count
ib_nAvai  out  $clog2(FETCH_W+1)  min(FETCH_W, DEPTH-count)
ib_store_en  out  DISP_W  bit i = (i < haz_nDispatched) && ib_data[i].fd_control.wr_mem

Behaviour:
- State: head, tail (log2 DEPTH bits, natural wrap), count (log2 DEPTH+1 bits), entry array.
- tail points at the next slot to fill.
- Reset (async, low): head=tail=count=0, all entries cleared.
- Reset outputs: ib_valid=0, ib_nIsnBuffer=0, ib_nAvai=FETCH_W, ib_store_en=0, ib_data=NOOP entries.
- Enqueue:
  - n = popcount(if_valid_in); entry k written to tail+k; tail += n.
  - Data is visible at the outputs the next cycle; no bypass into the same-cycle ib_data.
- ib_nAvai is computed from the registered count only. Slots freed by this cycle's dispatch are not reusable until the next cycle.
- Dispatch limit L = min(count, DISP_W, brLimit, stLimit), scanning slots i=0..DISP_W-1 from head:
  - brLimit: a branch at slot i ends the group at i+1.
  - brLimit: if branches before slot i already equal min(bs_nFree, MAX_BR_PER_GRP), the group ends at i, excluding that branch.
  - brLimit: bs_nFree=0 with a branch at head gives L=0.
  - stLimit: the group ends before the (sq_nAvailable+1)-th store (wr_mem).
  - Slots >= count are ignored by the scan.
- Unoffered ib_data slots output NOOP.
- Dequeue: head += haz_nDispatched.
- Count update: count_next = count + n - haz_nDispatched, width-safe with no intermediate truncation.
- Simultaneous enqueue and dequeue are independent. A full buffer with dispatch of 2 still reports ib_nAvai=0 that cycle.
- br_pred_wrong has priority over enqueue and dequeue that cycle:
  - next cycle head=tail=count=0;
  - the same-cycle enqueue is dropped;
  - ib_store_en is still driven combinationally from haz_nDispatched.
- Wrap-around: pointer arithmetic is modulo DEPTH. Offered slots may straddle index DEPTH-1 to 0.
- Illegal inputs (n > ib_nAvai, haz_nDispatched > ib_nIsnBuffer, non-thermometer if_valid_in): state is undefined. Simulation assertions fire.

Optional Feature:
Macro INSTR_BUFFER_DEBUG_EN.
- Defined:
  - adds outputs dbg_head, dbg_tail, dbg_count, dbg_buffer (DEPTH x IBEntry_t);
  - adds dbg_stall_cycles (32-bit): increments when count>0 and ib_nIsnBuffer=0, clears on reset, saturates at max.
- Undefined: none of these ports or the counter exist. Core behaviour is identical.

Decomposition:
- Shared package:
  - IBEntry_t, FD_control_t, INSTRUCTION, PC typedefs;
  - NOOP_IB_ENTRY constant;
  - the SD delay macro.
- Parametric pointer widths are derived locally from DEPTH.
- Sub-module ib_group_limiter (combinational): takes DISP_W head entries, count, bs_nFree and sq_nAvailable; returns L. It is unit-testable in isolation.

Test Plan:
- Reset low mid-stream with count=5 -> outputs drop asynchronously: count=0, ib_valid=0, ib_nAvai=2; after release, enqueue 2 -> next cycle ib_nIsnBuffer=2.
- Fill 8 non-branch entries, no dispatch -> ib_nAvai 2,2,2,1(count=7),0; a further if_valid_in=00 holds count=8.
- Head=6, tail=6 after wrap: enqueue 2, next cycle dispatch 2 -> ib_data[0]=slot6, ib_data[1]=slot7; then slots 0/1 offered, head=2.
- Head entry ALU, head+1 branch, bs_nFree=0 -> L=1. Same with bs_nFree=3 -> L=2. Branch at head with bs_nFree=3 -> L=1.
- Two stores at head, sq_nAvailable=1 -> L=1; haz_nDispatched=1 -> ib_store_en=01. sq_nAvailable=0 -> L=0, ib_store_en=00.
- count=4, if_valid_in=11, haz_nDispatched=2, br_pred_wrong=1 -> next cycle count=0, head=tail=0; the enqueued pair is absent.

Source files
------------

// File: rtl/instr_buffer_nway_pkg.sv
// rtl/instr_buffer_nway_pkg.sv - shared types and constants for the n-way instruction buffer
`ifndef SD
`define SD
`endif

package instr_buffer_nway_pkg;

    typedef logic [31:0] INSTRUCTION;
    typedef logic [31:0] PC;

    typedef struct packed {
        logic rd_mem;
        logic wr_mem;
        logic cond_branch;
        logic uncond_branch;
        logic halt;
        logic illegal;
        logic valid_inst;
    } FD_control_t;

    typedef struct packed {
        INSTRUCTION  instruction;
        FD_control_t fd_control;
        PC           pred_NPC;
        PC           not_taken_NPC;
        logic        bp_pred_taken;
    } IBEntry_t;

    localparam INSTRUCTION NOOP_INST = 32'h47ff_041f;

    localparam IBEntry_t NOOP_IB_ENTRY = '{
        instruction:   NOOP_INST,
        fd_control:    '0,
        pred_NPC:      '0,
        not_taken_NPC: '0,
        bp_pred_taken: 1'b0
    };

    function automatic logic is_branch(input IBEntry_t e);
        return e.fd_control.cond_branch | e.fd_control.uncond_branch;
    endfunction

endpackage

// File: rtl/instr_buffer_nway_ib_group_limiter.sv
// rtl/instr_buffer_nway_ib_group_limiter.sv - dispatch group length from branch and store budgets
module ib_group_limiter #(
    parameter int DEPTH          = 8,
    parameter int DISP_W         = 2,
    parameter int BS_DEPTH       = 8,
    parameter int MAX_BR_PER_GRP = 1
) (
    input  logic [DISP_W-1:0]             head_is_branch,
    input  logic [DISP_W-1:0]             head_is_store,
    input  logic [$clog2(DEPTH):0]        count,
    input  logic [$clog2(BS_DEPTH+1)-1:0] bs_nFree,
    input  logic [$clog2(DISP_W+1)-1:0]   sq_nAvailable,
    output logic [$clog2(DISP_W+1)-1:0]   limit
);

    localparam int LW = $clog2(DISP_W + 1);

    int   lim;
    int   br_seen;
    int   st_seen;
    int   br_cap;
    logic stop;

    // A branch always closes its group; a branch beyond the budget or a store
    // beyond the free queue slots closes it just before that slot.
    always_comb begin
        br_cap  = (int'(bs_nFree) < MAX_BR_PER_GRP) ? int'(bs_nFree) : MAX_BR_PER_GRP;
        lim     = 0;
        br_seen = 0;
        st_seen = 0;
        stop    = 1'b0;
        for (int i = 0; i < DISP_W; i++) begin
            if (!stop) begin
                if (i >= int'(count)) begin
                    stop = 1'b1;
                end else if (head_is_branch[i] && (br_seen >= br_cap)) begin
                    stop = 1'b1;
                end else if (head_is_store[i] && (st_seen >= int'(sq_nAvailable))) begin
                    stop = 1'b1;
                end else begin
                    lim = i + 1;
                    if (head_is_store[i]) begin
                        st_seen = st_seen + 1;
                    end
                    if (head_is_branch[i]) begin
                        br_seen = br_seen + 1;
                        stop    = 1'b1;
                    end
                end
            end
        end
        limit = LW'(lim);
    end

endmodule

// File: rtl/instr_buffer_nway.sv
// rtl/instr_buffer_nway.sv - circular fetch-to-dispatch buffer; INSTR_BUFFER_DEBUG_EN adds debug taps
module instr_buffer_nway
    import instr_buffer_nway_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int FETCH_W        = 2,
    parameter int DISP_W         = 2,
    parameter int MAX_BR_PER_GRP = 1,
    parameter int BS_DEPTH       = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          br_pred_wrong,
    input  logic [FETCH_W-1:0]            if_valid_in,
    input  IBEntry_t                      if_entry_in [FETCH_W],
    input  logic [$clog2(DISP_W+1)-1:0]   haz_nDispatched,
    input  logic [$clog2(BS_DEPTH+1)-1:0] bs_nFree,
    input  logic [$clog2(DISP_W+1)-1:0]   sq_nAvailable,
    output IBEntry_t                      ib_data [DISP_W],
    output logic [DISP_W-1:0]             ib_valid,
    output logic [$clog2(DISP_W+1)-1:0]   ib_nIsnBuffer,
    output logic [$clog2(FETCH_W+1)-1:0]  ib_nAvai,
    output logic [DISP_W-1:0]             ib_store_en
`ifdef INSTR_BUFFER_DEBUG_EN
    ,
    output logic [$clog2(DEPTH)-1:0]      dbg_head,
    output logic [$clog2(DEPTH)-1:0]      dbg_tail,
    output logic [$clog2(DEPTH):0]        dbg_count,
    output IBEntry_t                      dbg_buffer [DEPTH],
    output logic [31:0]                   dbg_stall_cycles
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int FW    = $clog2(FETCH_W + 1);
    localparam int DW    = $clog2(DISP_W + 1);

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    IBEntry_t         buffer [DEPTH];

    IBEntry_t         head_entries [DISP_W];
    logic [DISP_W-1:0] head_is_branch;
    logic [DISP_W-1:0] head_is_store;
    logic [DW-1:0]    grp_len;
    int               n_enq;
    int               free_slots;

    always_comb begin
        n_enq = 0;
        for (int k = 0; k < FETCH_W; k++) begin
            if (if_valid_in[k]) begin
                n_enq = n_enq + 1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DISP_W; i++) begin
            head_entries[i]   = buffer[head + PTR_W'(i)];
            head_is_branch[i] = is_branch(head_entries[i]);
            head_is_store[i]  = head_entries[i].fd_control.wr_mem;
        end
    end

    ib_group_limiter #(
        .DEPTH          (DEPTH),
        .DISP_W         (DISP_W),
        .BS_DEPTH       (BS_DEPTH),
        .MAX_BR_PER_GRP (MAX_BR_PER_GRP)
    ) u_limiter (
        .head_is_branch (head_is_branch),
        .head_is_store  (head_is_store),
        .count          (count),
        .bs_nFree       (bs_nFree),
        .sq_nAvailable  (sq_nAvailable),
        .limit          (grp_len)
    );

    // Free space comes from the registered count only, so slots released by
    // this cycle's dispatch are not offered to fetch until next cycle.
    always_comb begin
        free_slots = DEPTH - int'(count);
        ib_nAvai   = FW'((free_slots < FETCH_W) ? free_slots : FETCH_W);
    end

    always_comb begin
        ib_nIsnBuffer = grp_len;
        for (int i = 0; i < DISP_W; i++) begin
            ib_valid[i]    = (i < int'(grp_len));
            ib_data[i]     = (i < int'(grp_len)) ? head_entries[i] : NOOP_IB_ENTRY;
            ib_store_en[i] = (i < int'(grp_len)) && (i < int'(haz_nDispatched))
                             && head_entries[i].fd_control.wr_mem;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buffer[i] <= NOOP_IB_ENTRY;
            end
        end else if (br_pred_wrong) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            for (int k = 0; k < FETCH_W; k++) begin
                if (if_valid_in[k]) begin
                    buffer[tail + PTR_W'(k)] <= if_entry_in[k];
                end
            end
            tail  <= tail + PTR_W'(n_enq);
            head  <= head + PTR_W'(haz_nDispatched);
            count <= CNT_W'(int'(count) + n_enq - int'(haz_nDispatched));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            assert (n_enq <= int'(ib_nAvai));
            assert (int'(haz_nDispatched) <= int'(ib_nIsnBuffer));
            assert ((if_valid_in & (if_valid_in + FETCH_W'(1))) == '0);
        end
    end

`ifdef INSTR_BUFFER_DEBUG_EN
    assign dbg_head  = head;
    assign dbg_tail  = tail;
    assign dbg_count = count;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            dbg_buffer[i] = buffer[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dbg_stall_cycles <= '0;
        end else if ((count != '0) && (grp_len == '0) && (dbg_stall_cycles != '1)) begin
            dbg_stall_cycles <= dbg_stall_cycles + 32'd1;
        end
    end
`endif

endmodule
